// File: rtl/core_pkg.sv
// Shared types and constants for the data-memory arbiter and its ID FIFO.
package core_pkg;
  typedef logic arb_id_t;
  localparam int ARB_NUM_MASTERS     = 2;
  localparam int ARB_MAX_OUTSTANDING = 4;
endpackage

// File: rtl/dmem_arb_id_fifo.sv
// In-order ID FIFO: circular buffer with wrapping pointers and a separate count.
module dmem_arb_id_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  arb_id_t          push_id_i,
  input  logic             pop_i,
  output arb_id_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  arb_id_t [DEPTH-1:0] buf_q, buf_d;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    buf_d = buf_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      buf_d[wr_q] = push_id_i;
      wr_d        = ptr_next(wr_q);
    end
    if (pop_i) begin
      rd_d = ptr_next(rd_q);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = buf_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with in-order response routing.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m0 always wins.
module dmem_arbiter
  import core_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               m0_req_i,
  output logic                               m0_gnt_o,
  input  logic [31:0]                        m0_addr_i,
  input  logic                               m0_wen_i,
  input  logic [3:0]                         m0_ben_i,
  input  logic [31:0]                        m0_wdata_i,
  output logic                               m0_rvalid_o,
  output logic [31:0]                        m0_rdata_o,
  input  logic                               m1_req_i,
  output logic                               m1_gnt_o,
  input  logic [31:0]                        m1_addr_i,
  input  logic                               m1_wen_i,
  input  logic [3:0]                         m1_ben_i,
  input  logic [31:0]                        m1_wdata_i,
  output logic                               m1_rvalid_o,
  output logic [31:0]                        m1_rdata_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic [31:0]                        mem_addr_o,
  output logic                               mem_wen_o,
  output logic [3:0]                         mem_ben_o,
  output logic [31:0]                        mem_wdata_o,
  input  logic                               mem_rvalid_i,
  input  logic [31:0]                        mem_rdata_i,
  output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                               err_o
);

  logic    sel_valid;
  arb_id_t sel_id;
  arb_id_t tie_winner;
  logic    grant;
  logic    pop;
  arb_id_t head_id;
  logic    fifo_full;
  logic    fifo_empty;
  logic    err_q, err_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  arb_id_t prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (grant) prio_d = ~sel_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign tie_winner = prio_q;
`else
  assign tie_winner = 1'b0;
`endif

  always_comb begin
    sel_valid = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) sel_id = tie_winner;
    else                      sel_id = arb_id_t'(m1_req_i);

    mem_addr_o  = '0;
    mem_wen_o   = 1'b0;
    mem_ben_o   = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_id == 1'b1) begin
        mem_addr_o  = m1_addr_i;
        mem_wen_o   = m1_wen_i;
        mem_ben_o   = m1_ben_i;
        mem_wdata_o = m1_wdata_i;
      end else begin
        mem_addr_o  = m0_addr_i;
        mem_wen_o   = m0_wen_i;
        mem_ben_o   = m0_ben_i;
        mem_wdata_o = m0_wdata_i;
      end
    end
  end

  // Full comes from the registered count, so a same-cycle pop does not reopen the port.
  assign mem_req_o = sel_valid & ~fifo_full & ~rst_i;
  assign grant     = mem_req_o & mem_gnt_i;
  assign m0_gnt_o  = grant & (sel_id == 1'b0);
  assign m1_gnt_o  = grant & (sel_id == 1'b1);

  assign pop         = mem_rvalid_i & ~fifo_empty & ~rst_i;
  assign m0_rvalid_o = pop & (head_id == 1'b0);
  assign m1_rvalid_o = pop & (head_id == 1'b1);
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

  assign err_d = err_q | (mem_rvalid_i & fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

  dmem_arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (grant),
    .push_id_i (sel_id),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; responses are checked by a scoreboard monitor.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_gnt_o, m0_wen_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_ben_i;
  logic        m1_req_i, m1_gnt_o, m1_wen_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_ben_i;
  logic        mem_req_o, mem_gnt_i, mem_wen_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_ben_o;
  logic [1:0]  outstanding_o;
  logic        err_o;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_wen_i(m0_wen_i),
    .m0_ben_i(m0_ben_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_wen_i(m1_wen_i),
    .m1_ben_i(m1_ben_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
    .mem_ben_o(mem_ben_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every master response must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (m0_rvalid_o || m1_rvalid_o) begin
      n_checks++;
      if (m0_rvalid_o && m1_rvalid_o) begin
        n_err++;
        $display("FAIL rvalid_both: got m0=1 m1=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rvalid_unexpected: got m%0d rvalid expected none", m1_rvalid_o ? 1 : 0);
      end else begin
        exp_t e;
        logic [31:0] rd;
        e  = exp_q.pop_front();
        rd = m1_rvalid_o ? m1_rdata_o : m0_rdata_o;
        if (m1_rvalid_o !== e.id || rd !== e.data) begin
          n_err++;
          $display("FAIL rvalid_route: got m%0d data %h expected m%0d data %h",
                   m1_rvalid_o ? 1 : 0, rd, e.id, e.data);
        end
      end
    end
  end

  task automatic idle();
    m0_req_i = 0; m0_addr_i = 0; m0_wen_i = 0; m0_ben_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_addr_i = 0; m1_wen_i = 0; m1_ben_i = 0; m1_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic rsp(input logic id, input logic [31:0] data);
    mem_rvalid_i = 1;
    mem_rdata_i  = data;
    exp_q.push_back('{id: id, data: data});
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    m0_req_i = 1; m1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    settle();
    chk("rst_m0_gnt", {31'b0, m0_gnt_o}, 0);
    chk("rst_m1_gnt", {31'b0, m1_gnt_o}, 0);
    chk("rst_mem_req", {31'b0, mem_req_o}, 0);
    chk("rst_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 0);
    step();
    idle();
    step();
    rst_i = 0;
    settle();
    chk("rst_outstanding", {30'b0, outstanding_o}, 0);
    chk("rst_err", {31'b0, err_o}, 0);
  endtask

  logic g_exp [1:4];

  initial begin
    rst_i = 1;
    idle();
    step();
    do_reset();

    // Single master load, memory initially stalls one cycle.
    m0_req_i = 1; m0_addr_i = 32'h100; m0_ben_i = 4'hF;
    settle();
    chk("stall_mem_req", {31'b0, mem_req_o}, 1);
    chk("stall_m0_gnt", {31'b0, m0_gnt_o}, 0);
    chk("stall_addr", mem_addr_o, 32'h100);
    step();
    mem_gnt_i = 1;
    settle();
    chk("single_m0_gnt", {31'b0, m0_gnt_o}, 1);
    chk("single_m1_gnt", {31'b0, m1_gnt_o}, 0);
    step();
    idle();
    settle();
    chk("single_out1", {30'b0, outstanding_o}, 1);
    chk("idle_addr", mem_addr_o, 0);
    chk("idle_mem_req", {31'b0, mem_req_o}, 0);
    step();
    rsp(0, 32'hDEADBEEF);
    step();
    idle();
    settle();
    chk("single_out0", {30'b0, outstanding_o}, 0);

    // Tie arbitration from a fresh reset.
    do_reset();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    g_exp[1] = 0; g_exp[2] = 1; g_exp[3] = 0; g_exp[4] = 1;
`else
    g_exp[1] = 0; g_exp[2] = 0; g_exp[3] = 0; g_exp[4] = 0;
`endif
    for (int c = 1; c <= 4; c++) begin
      idle();
      m0_req_i = 1; m0_addr_i = 32'h200 + c; m1_req_i = 1; m1_addr_i = 32'h300 + c;
      mem_gnt_i = 1;
      if (c > 1) rsp(g_exp[c-1], 32'hA0 + c);
      settle();
      chk($sformatf("tie_m0_gnt_c%0d", c), {31'b0, m0_gnt_o}, {31'b0, ~g_exp[c]});
      chk($sformatf("tie_m1_gnt_c%0d", c), {31'b0, m1_gnt_o}, {31'b0, g_exp[c]});
      chk($sformatf("tie_addr_c%0d", c), mem_addr_o, g_exp[c] ? 32'h300 + c : 32'h200 + c);
      if (c > 1) chk($sformatf("tie_out_c%0d", c), {30'b0, outstanding_o}, 1);
      step();
    end
    idle();
    m1_req_i = 1; mem_gnt_i = 1;
    rsp(g_exp[4], 32'hA5);
    settle();
    chk("tie_m1_alone_gnt", {31'b0, m1_gnt_o}, 1);
    step();
    idle();
    rsp(1, 32'hA6);
    step();
    idle();
    settle();
    chk("tie_out_end", {30'b0, outstanding_o}, 0);

    // Full: two grants with no responses block the third.
    m0_req_i = 1; mem_gnt_i = 1;
    step();
    idle();
    m1_req_i = 1; mem_gnt_i = 1;
    step();
    idle();
    m0_req_i = 1; mem_gnt_i = 1;
    settle();
    chk("full_out", {30'b0, outstanding_o}, 2);
    chk("full_gnt", {31'b0, m0_gnt_o}, 0);
    chk("full_mem_req", {31'b0, mem_req_o}, 0);
    step();
    rsp(0, 32'h55);
    settle();
    chk("full_pop_gnt", {31'b0, m0_gnt_o}, 0);
    chk("full_pop_mem_req", {31'b0, mem_req_o}, 0);
    step();
    mem_rvalid_i = 0;
    settle();
    chk("full_after_pop_out", {30'b0, outstanding_o}, 1);
    chk("full_after_pop_gnt", {31'b0, m0_gnt_o}, 1);
    step();
    idle();
    rsp(1, 32'h66);
    step();
    idle();
    rsp(0, 32'h77);
    step();
    idle();
    settle();
    chk("full_drain_out", {30'b0, outstanding_o}, 0);

    // In-order routing: m1 store then m0 load.
    m1_req_i = 1; m1_addr_i = 32'h400; m1_wen_i = 1; m1_ben_i = 4'h3; m1_wdata_i = 32'hCAFE;
    mem_gnt_i = 1;
    settle();
    chk("route_m1_gnt", {31'b0, m1_gnt_o}, 1);
    chk("route_wen", {31'b0, mem_wen_o}, 1);
    chk("route_ben", {28'b0, mem_ben_o}, 32'h3);
    chk("route_wdata", mem_wdata_o, 32'hCAFE);
    step();
    idle();
    m0_req_i = 1; m0_addr_i = 32'h404; mem_gnt_i = 1;
    settle();
    chk("route_m0_gnt", {31'b0, m0_gnt_o}, 1);
    step();
    idle();
    rsp(1, 32'h11);
    settle();
    chk("route_m0_quiet", {31'b0, m0_rvalid_o}, 0);
    step();
    idle();
    rsp(0, 32'h22);
    settle();
    chk("route_m1_quiet", {31'b0, m1_rvalid_o}, 0);
    step();
    idle();

    // Stray response sets a sticky error, cleared only by reset.
    rsp(0, 32'h99);
    void'(exp_q.pop_back());
    settle();
    chk("err_no_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 0);
    chk("err_before", {31'b0, err_o}, 0);
    step();
    idle();
    settle();
    chk("err_set", {31'b0, err_o}, 1);
    chk("err_out0", {30'b0, outstanding_o}, 0);
    step();
    step();
    chk("err_held", {31'b0, err_o}, 1);
    do_reset();
    step();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between two requesters: master 0 (the core's load/store path) and master 1 (a debug/DMA agent). Each request is granted with a req/gnt handshake, and each response is returned with rvalid. The block tracks in-order outstanding transactions in a small ID FIFO so every response is routed back to the master that issued it. It sits between the core's memory stage and the data memory.

## Interface
Parameters:
- OUTSTANDING, 2: maximum number of in-flight transactions (granted, response not yet returned); legal range 1..4.

Ports. `mX` denotes both masters, m0 and m1, one port set each.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- mX_req_i  in  1  request valid.
- mX_gnt_o  out  1  request accepted this cycle.
- mX_addr_i  in  32  byte address.
- mX_wen_i  in  1  1 = store, 0 = load.
- mX_ben_i  in  4  byte enables.
- mX_wdata_i  in  32  store data.
- mX_rvalid_o  out  1  response for this master this cycle.
- mX_rdata_o  out  32  load data; driven from mem_rdata_i.
- mem_req_o  out  1  request to memory.
- mem_gnt_i  in  1  memory accepts the request.
- mem_addr_o, mem_wen_o, mem_ben_o, mem_wdata_o  out  32/1/4/32  fields muxed from the selected master.
- mem_rvalid_i  in  1  in-order response valid.
- mem_rdata_i  in  32  response data.
- outstanding_o  out  $clog2(OUTSTANDING+1)  current in-flight count.
- err_o  out  1  sticky: rvalid arrived with no transaction outstanding.

## Operation
- Masters hold req and all request fields stable from req high until the gnt cycle.
- Selection, combinational:
  - Only one master requesting: that master is selected.
  - Both requesting: the arbitration policy decides (see Configuration).
- Request side:
  - mem_req_o = (m0_req_i | m1_req_i) & !full.
  - mem_* request fields come from the selected master.
  - When nothing is selected, mem_* fields are 0.
- Grant: mX_gnt_o = selected(X) & mem_gnt_i & !full. At most one gnt is high per cycle.
- On a grant:
  - The master ID is pushed into the ID FIFO.
  - outstanding increments.
- On mem_rvalid_i with the FIFO not empty:
  - The head ID is popped.
  - The matching mX_rvalid_o is asserted in the same cycle.
  - outstanding decrements.
- mX_rdata_o = mem_rdata_i for both masters at all times; it is qualified only by rvalid.
- Simultaneous grant and response in one cycle: push and pop both occur and outstanding is unchanged.
- Full (outstanding == OUTSTANDING):
  - No grant, and mem_req_o = 0, even if a pop occurs in the same cycle.
  - The full flag is registered state, not bypassed.
- mem_rvalid_i while empty:
  - No mX_rvalid_o is asserted.
  - The FIFO is unchanged.
  - err_o is set and held until reset.
- Stores also return rvalid (write acknowledge) and are routed the same way as loads.
- A grant and a response may target the same master in the same cycle; both are legal.

## Timing
- Grant path is combinational: zero-cycle request-to-gnt when mem_gnt_i is high and the FIFO is not full.
- Response routing is combinational: mX_rvalid_o is asserted in the same cycle as mem_rvalid_i.
- The ID FIFO, outstanding count, priority pointer and err_o update on the clock edge after the event.
- Reset, with rst_i high at a rising edge:
  - FIFO is emptied and outstanding_o = 0.
  - err_o = 0.
  - Priority pointer is set to m0.
  - All gnt/rvalid/mem_req outputs are 0 while rst_i is high.
- Reset mid-transaction: in-flight responses are discarded. Memory-side quiescing is the system's responsibility. A stray rvalid after reset sets err_o.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the master not granted most recently wins.
  - The pointer updates only on an actual grant.
  - After reset, m0 wins the first tie.
- Undefined: fixed priority, m0 always wins ties, and no pointer register exists.

## Structure
- core_pkg adds:
  - typedef arb_id_t (1-bit master ID).
  - constant ARB_NUM_MASTERS = 2.
  - constant ARB_MAX_OUTSTANDING = 4.
- Sub-module dmem_arb_id_fifo: synchronous FIFO of arb_id_t, depth OUTSTANDING.
  - Ports: push/pop, head, full, empty and count.
  - Implemented with a circular buffer, read/write pointers that wrap modulo depth, and a separate count register.

## Test plan
- Single master: m0 load to 0x100; memory grants immediately and returns rvalid 2 cycles later with 0xDEADBEEF → m0_gnt is high in the request cycle, m0_rvalid is high with rdata 0xDEADBEEF, and m1_rvalid stays 0.
- Tie, fixed priority: m0 and m1 request continuously with mem_gnt=1 → m0 is granted every cycle and m1 is starved until m0 drops req.
- Tie with DMEM_ARB_ROUND_ROBIN_EN defined: both request continuously → grants alternate m0, m1, m0, m1 starting from m0 after reset.
- Full: OUTSTANDING=2, two grants with no responses → the third request gets gnt=0 and mem_req_o=0. With a response in the following cycle, gnt returns one cycle after the pop.
- In-order routing: grant m1 then m0, with responses 0x11 then 0x22 → m1 receives 0x11 and m0 receives 0x22. Push and pop in the same cycle keep outstanding_o unchanged.
- Error and reset: rvalid with outstanding_o=0 → err_o=1 on the next cycle, no master rvalid, err_o held; after rst_i is pulsed, err_o=0, outstanding_o=0 and no gnt/rvalid is asserted.
